// File: rtl/fbuf_pkg.sv
// Shared types and frame constants for the framebuffer write scheduler.
//   fill_state_t : fill engine state encoding
//   fbuf_wr_t    : registered BRAM write bundle {en, addr, data}
//   fill_cmd_t   : latched rectangle command {x0, y0, w, h, color}
//   frame_offset : y*W + x at widened arithmetic width
package fbuf_pkg;

   localparam int unsigned FRAME_WIDTH_SCALED  = 640;
   localparam int unsigned FRAME_HEIGHT_SCALED = 480;
   localparam int unsigned FBUF_ADDR_WIDTH     = 19;
   localparam int unsigned FBUF_DATA_WIDTH     = 8;
   localparam int unsigned COORD_WIDTH         = 12;
   localparam int unsigned ARITH_WIDTH         = FBUF_ADDR_WIDTH + COORD_WIDTH;

   typedef logic [COORD_WIDTH-1:0]     coord_t;
   typedef logic [FBUF_ADDR_WIDTH-1:0] addr_t;
   typedef logic [FBUF_DATA_WIDTH-1:0] data_t;
   typedef logic [ARITH_WIDTH-1:0]     arith_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } fill_state_t;

   typedef struct packed {
      logic  en;
      addr_t addr;
      data_t data;
   } fbuf_wr_t;

   typedef struct packed {
      coord_t x0;
      coord_t y0;
      coord_t w;
      coord_t h;
      data_t  color;
   } fill_cmd_t;

   // Linear pixel offset; caller truncates to the port width.
   function automatic arith_t frame_offset(input coord_t x, input coord_t y);
      return ARITH_WIDTH'(y) * ARITH_WIDTH'(FRAME_WIDTH_SCALED) + ARITH_WIDTH'(x);
   endfunction

endpackage

// File: rtl/fbuf_fill_scheduler_if.sv
// Bus bundle between the register decode (master) and the fill scheduler (slave).
//   px_*         : host single-pixel write handshake and drop pulse
//   fill_*       : rectangle fill command handshake and status
//   clear_req    : full-frame clear request
//   fbuf_*       : BRAM write port driven by the scheduler
interface fbuf_fill_scheduler_if;
   import fbuf_pkg::*;

   logic   px_valid;
   logic   px_ready;
   coord_t px_x;
   coord_t px_y;
   data_t  px_data;
   logic   px_drop;

   logic   fill_valid;
   logic   fill_ready;
   coord_t fill_x0;
   coord_t fill_y0;
   coord_t fill_w;
   coord_t fill_h;
   data_t  fill_color;
   logic   clear_req;
   logic   fill_busy;
   logic   fill_done;

   logic   fbuf_en_wr;
   logic   fbuf_wrea;
   addr_t  fbuf_addr;
   data_t  fbuf_data;

   modport master (
      output px_valid, px_x, px_y, px_data,
      output fill_valid, fill_x0, fill_y0, fill_w, fill_h, fill_color, clear_req,
      input  px_ready, px_drop, fill_ready, fill_busy, fill_done,
      input  fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data
   );

   modport slave (
      input  px_valid, px_x, px_y, px_data,
      input  fill_valid, fill_x0, fill_y0, fill_w, fill_h, fill_color, clear_req,
      output px_ready, px_drop, fill_ready, fill_busy, fill_done,
      output fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data
   );

endinterface

// File: rtl/fbuf_fill_walker.sv
// Rectangle walker: clips the command on load, then steps col/row per advance.
//   clk, rst    : clock, synchronous active-high reset
//   load        : capture clipped size and first row base (LOAD state)
//   advance     : current pixel consumed by the port
//   x0,y0,w,h   : latched rectangle command
//   addr        : address of the current pixel
//   last        : current pixel is the final one of the rectangle
//   empty_c     : command produces no writes (decoded from the inputs)
module fbuf_fill_walker
   import fbuf_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   load,
   input  logic   advance,
   input  coord_t x0,
   input  coord_t y0,
   input  coord_t w,
   input  coord_t h,
   output addr_t  addr,
   output logic   last,
   output logic   empty_c
);

   localparam coord_t FW = COORD_WIDTH'(FRAME_WIDTH_SCALED);
   localparam coord_t FH = COORD_WIDTH'(FRAME_HEIGHT_SCALED);
   localparam arith_t FW_A = ARITH_WIDTH'(FRAME_WIDTH_SCALED);

   coord_t w_eff, h_eff, col, row;
   arith_t row_base;
   coord_t x_room, y_room, w_clip, h_clip;

   // Clip to the frame; room values are only meaningful when the origin is inside.
   always_comb begin
      x_room  = FW - x0;
      y_room  = FH - y0;
      w_clip  = (w < x_room) ? w : x_room;
      h_clip  = (h < y_room) ? h : y_room;
      empty_c = (x0 >= FW) || (y0 >= FH) || (w == '0) || (h == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_eff    <= '0;
         h_eff    <= '0;
         col      <= '0;
         row      <= '0;
         row_base <= '0;
      end else if (load) begin
         w_eff    <= w_clip;
         h_eff    <= h_clip;
         col      <= '0;
         row      <= '0;
         row_base <= frame_offset(x0, y0);
      end else if (advance) begin
         // Column wrap moves the base down one frame line.
         if (col == w_eff - COORD_WIDTH'(1)) begin
            col      <= '0;
            row      <= row + COORD_WIDTH'(1);
            row_base <= row_base + FW_A;
         end else begin
            col <= col + COORD_WIDTH'(1);
         end
      end
   end

   assign addr = FBUF_ADDR_WIDTH'(row_base + ARITH_WIDTH'(col));
   assign last = (row == h_eff - COORD_WIDTH'(1)) && (col == w_eff - COORD_WIDTH'(1));

endmodule

// File: rtl/fbuf_fill_scheduler.sv
// Merges host pixel writes and the rectangle fill/clear engine onto one BRAM port.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : slave side of fbuf_fill_scheduler_if (pixel/fill handshakes, status, BRAM port)
// Contested cycles alternate between the two sources; the fill takes the first one.
module fbuf_fill_scheduler
   import fbuf_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   fbuf_fill_scheduler_if.slave  bus
);

   localparam coord_t FW = COORD_WIDTH'(FRAME_WIDTH_SCALED);
   localparam coord_t FH = COORD_WIDTH'(FRAME_HEIGHT_SCALED);

   fill_state_t state, state_nxt;
   fill_cmd_t   cmd_q, cmd_nxt;
   fbuf_wr_t    wr_q, wr_nxt;
   logic        last_fill, last_fill_nxt;
   logic        px_drop_q, fill_done_q, fill_busy_q;

   logic        fill_pend, fill_wins, px_ready_c, fill_ready_c, px_acc, px_oob;
   addr_t       walk_addr;
   logic        walk_last, walk_empty_c;

   fbuf_fill_walker u_walker (
      .clk     (clk),
      .rst     (rst),
      .load    (state == LOAD),
      .advance (fill_wins),
      .x0      (cmd_q.x0),
      .y0      (cmd_q.y0),
      .w       (cmd_q.w),
      .h       (cmd_q.h),
      .addr    (walk_addr),
      .last    (walk_last),
      .empty_c (walk_empty_c)
   );

   // Arbitration and next port value.
   always_comb begin
      fill_pend     = (state == RUN);
      fill_wins     = fill_pend && (!bus.px_valid || !last_fill);
      px_ready_c    = !rst && !fill_wins;
      px_acc        = bus.px_valid && px_ready_c;
      px_oob        = (bus.px_x >= FW) || (bus.px_y >= FH);
      fill_ready_c  = !rst && (state == IDLE) && !bus.clear_req;
      last_fill_nxt = last_fill;
      if (fill_pend && bus.px_valid) last_fill_nxt = fill_wins;
      wr_nxt = '0;
      if (fill_wins) begin
         wr_nxt = '{en: 1'b1, addr: walk_addr, data: cmd_q.color};
      end else if (px_acc && !px_oob) begin
         wr_nxt = '{en: 1'b1,
                    addr: FBUF_ADDR_WIDTH'(frame_offset(bus.px_x, bus.px_y)),
                    data: bus.px_data};
      end
   end

   // Fill FSM next state; clear has priority over a simultaneous fill command.
   always_comb begin
      state_nxt = state;
      cmd_nxt   = cmd_q;
      case (state)
         IDLE: begin
            if (bus.clear_req) begin
               cmd_nxt   = '{x0: '0, y0: '0, w: FW, h: FH, color: '0};
               state_nxt = LOAD;
            end else if (bus.fill_valid) begin
               cmd_nxt   = '{x0: bus.fill_x0, y0: bus.fill_y0, w: bus.fill_w,
                             h: bus.fill_h, color: bus.fill_color};
               state_nxt = LOAD;
            end
         end
         LOAD:    state_nxt = walk_empty_c ? DONE : RUN;
         RUN:     if (fill_wins && walk_last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Command latch, arbitration history and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_q       <= '0;
         last_fill   <= 1'b0;
         wr_q        <= '0;
         px_drop_q   <= 1'b0;
         fill_done_q <= 1'b0;
         fill_busy_q <= 1'b0;
      end else begin
         cmd_q       <= cmd_nxt;
         last_fill   <= last_fill_nxt;
         wr_q        <= wr_nxt;
         px_drop_q   <= px_acc && px_oob;
         fill_done_q <= (state == DONE);
         fill_busy_q <= (state_nxt != IDLE);
      end
   end

   assign bus.px_ready   = px_ready_c;
   assign bus.fill_ready = fill_ready_c;
   assign bus.px_drop    = px_drop_q;
   assign bus.fill_busy  = fill_busy_q;
   assign bus.fill_done  = fill_done_q;
   assign bus.fbuf_en_wr = wr_q.en;
   assign bus.fbuf_wrea  = wr_q.en;
   assign bus.fbuf_addr  = wr_q.addr;
   assign bus.fbuf_data  = wr_q.data;

endmodule

// File: tb/tb_fbuf_fill_scheduler.sv
// Directed bench for fbuf_fill_scheduler with hand-computed port sequences.
module tb_fbuf_fill_scheduler;
   import fbuf_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fbuf_fill_scheduler_if bus ();

   fbuf_fill_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] wr(input logic en, input int unsigned addr, input int unsigned data);
      return {3'b000, en, en, FBUF_ADDR_WIDTH'(addr), FBUF_DATA_WIDTH'(data)};
   endfunction

   function automatic logic [31:0] port_now();
      return {3'b000, bus.fbuf_en_wr, bus.fbuf_wrea, bus.fbuf_addr, bus.fbuf_data};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.px_valid   = 1'b0;
      bus.px_x       = '0;
      bus.px_y       = '0;
      bus.px_data    = '0;
      bus.fill_valid = 1'b0;
      bus.fill_x0    = '0;
      bus.fill_y0    = '0;
      bus.fill_w     = '0;
      bus.fill_h     = '0;
      bus.fill_color = '0;
      bus.clear_req  = 1'b0;
   endtask

   task automatic set_px(input int unsigned x, input int unsigned y, input int unsigned d);
      bus.px_valid = 1'b1;
      bus.px_x     = COORD_WIDTH'(x);
      bus.px_y     = COORD_WIDTH'(y);
      bus.px_data  = FBUF_DATA_WIDTH'(d);
   endtask

   task automatic set_fill(input int unsigned x0, input int unsigned y0,
                           input int unsigned w, input int unsigned h, input int unsigned c);
      bus.fill_valid = 1'b1;
      bus.fill_x0    = COORD_WIDTH'(x0);
      bus.fill_y0    = COORD_WIDTH'(y0);
      bus.fill_w     = COORD_WIDTH'(w);
      bus.fill_h     = COORD_WIDTH'(h);
      bus.fill_color = FBUF_DATA_WIDTH'(c);
   endtask

   int unsigned t3_addr [4]  = '{638, 639, 1278, 1279};
   int unsigned t4_addr [11] = '{6410, 6410, 0, 6410, 640, 6410, 1280, 6410, 1920, 6410, 6410};
   int unsigned t4_data [11] = '{8'h77, 8'h77, 8'h22, 8'h77, 8'h22, 8'h77, 8'h22, 8'h77, 8'h22, 8'h77, 8'h77};

   initial begin
      drive_idle();
      rst = 1'b1;
      tick();
      tick();
      // Reset: handshakes held low even with requests present.
      bus.px_valid   = 1'b1;
      bus.fill_valid = 1'b1;
      #1;
      check("rst_px_ready", 32'(bus.px_ready), 32'd0);
      check("rst_fill_ready", 32'(bus.fill_ready), 32'd0);
      tick();
      drive_idle();
      check("rst_port", port_now(), 32'd0);
      check("rst_status", {29'd0, bus.px_drop, bus.fill_busy, bus.fill_done}, 32'd0);
      rst = 1'b0;
      #1;
      check("idle_fill_ready", 32'(bus.fill_ready), 32'd1);

      // In-frame pixel (3,2) -> 2*640+3.
      set_px(3, 2, 8'h5A);
      #1;
      check("px1_ready", 32'(bus.px_ready), 32'd1);
      tick();
      drive_idle();
      check("px1_write", port_now(), wr(1'b1, 1283, 8'h5A));
      check("px1_nodrop", 32'(bus.px_drop), 32'd0);
      tick();
      check("px1_idle", port_now(), 32'd0);

      // Out-of-frame pixels are accepted and dropped.
      set_px(640, 0, 8'hAA);
      #1;
      check("px2_ready", 32'(bus.px_ready), 32'd1);
      tick();
      drive_idle();
      check("px2_nowrite", port_now(), 32'd0);
      check("px2_drop", 32'(bus.px_drop), 32'd1);
      set_px(0, 480, 8'hAB);
      tick();
      drive_idle();
      check("px3_nowrite", port_now(), 32'd0);
      check("px3_drop", 32'(bus.px_drop), 32'd1);
      // Last in-frame pixel: 479*640+639.
      set_px(639, 479, 8'hC3);
      tick();
      drive_idle();
      check("px4_write", port_now(), wr(1'b1, 307199, 8'hC3));
      check("px4_nodrop", 32'(bus.px_drop), 32'd0);
      tick();

      // Fill clipped at the right edge: w_eff=2, h_eff=2.
      set_fill(638, 0, 4, 2, 8'h11);
      #1;
      check("f1_ready", 32'(bus.fill_ready), 32'd1);
      tick();
      drive_idle();
      check("f1_load_busy", 32'(bus.fill_busy), 32'd1);
      check("f1_c0", port_now(), 32'd0);
      tick();
      check("f1_c1", port_now(), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("f1_w%0d", i), port_now(), wr(1'b1, t3_addr[i], 8'h11));
         check($sformatf("f1_nd%0d", i), 32'(bus.fill_done), 32'd0);
      end
      tick();
      check("f1_done", 32'(bus.fill_done), 32'd1);
      check("f1_done_port", port_now(), 32'd0);
      check("f1_busy_off", 32'(bus.fill_busy), 32'd0);
      tick();
      check("f1_done_pulse", 32'(bus.fill_done), 32'd0);

      // Fill 1x4 against continuous pixel traffic at (10,10): alternating grants.
      set_px(10, 10, 8'h77);
      set_fill(0, 0, 1, 4, 8'h22);
      tick();
      bus.fill_valid = 1'b0;
      for (int i = 0; i < 11; i++) begin
         check($sformatf("f2_w%0d", i), port_now(), wr(1'b1, t4_addr[i], t4_data[i]));
         check($sformatf("f2_d%0d", i), 32'(bus.fill_done), (i == 9) ? 32'd1 : 32'd0);
         if (i == 1) check("f2_px_blocked", 32'(bus.px_ready), 32'd0);
         if (i == 2) check("f2_px_turn", 32'(bus.px_ready), 32'd1);
         tick();
      end
      drive_idle();
      tick();

      // Zero-width fill: no writes, done pulse only.
      set_fill(1, 1, 0, 5, 8'h44);
      tick();
      drive_idle();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("f3_port%0d", i), port_now(), 32'd0);
         check($sformatf("f3_d%0d", i), 32'(bus.fill_done), (i == 2) ? 32'd1 : 32'd0);
         tick();
      end

      // Clear beats a simultaneous fill; writes zeros from address 0 across a row wrap.
      bus.clear_req = 1'b1;
      set_fill(5, 5, 2, 2, 8'h33);
      #1;
      check("clr_fill_ready", 32'(bus.fill_ready), 32'd0);
      tick();
      drive_idle();
      check("clr_c0", port_now(), 32'd0);
      tick();
      check("clr_c1", port_now(), 32'd0);
      for (int k = 0; k < 700; k++) begin
         tick();
         check($sformatf("clr_w%0d", k), port_now(), wr(1'b1, k, 0));
      end
      // Reset in the middle of the clear.
      rst = 1'b1;
      tick();
      check("clr_rst_port", port_now(), 32'd0);
      check("clr_rst_status", {29'd0, bus.px_drop, bus.fill_busy, bus.fill_done}, 32'd0);
      check("clr_rst_fill_ready", 32'(bus.fill_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("clr_post_fill_ready", 32'(bus.fill_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("clr_post_port%0d", i), port_now(), 32'd0);
         check($sformatf("clr_post_done%0d", i), 32'(bus.fill_done), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
